// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage.
// - alu_op_e    : ALU operation codes driven onto the ALU's ALUop input
// - OPC_* / F3_* / F7_* : RV32I opcode, funct3 and funct7 field values
// - LINK_OFFSET : byte offset of the return address for JAL/JALR
// - base_op()   : maps an OP/OP-IMM funct3 to its ALU operation
package alu_issue_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_COPY_B = 5'd10,
    ALU_EQ     = 5'd11,
    ALU_NE     = 5'd12,
    ALU_LT     = 5'd13,
    ALU_GE     = 5'd14,
    ALU_LTU    = 5'd15,
    ALU_GEU    = 5'd16
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int LINK_OFFSET = 4;

  // Register-register and register-immediate forms share one funct3 table;
  // the SUB/SRA variants are selected separately by funct7.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: base_op = ALU_ADD;
      F3_SLL:     base_op = ALU_SLL;
      F3_SLT:     base_op = ALU_SLT;
      F3_SLTU:    base_op = ALU_SLTU;
      F3_XOR:     base_op = ALU_XOR;
      F3_SR:      base_op = ALU_SRL;
      F3_OR:      base_op = ALU_OR;
      default:    base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into an ALU request.
// - inst, pc, rs1_data, rs2_data : instruction word and its operands
// - alu_op, a, b                 : ALU operation and operands
// - rd, rd_we                    : destination register and write enable (0 for x0)
// - is_branch                    : conditional branch, ALU result is the taken flag
// - illegal                      : unrecognised encoding; alu_op=ADD, rd_we=0
module alu_op_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic [31:0]    inst,
  input  logic [DW-1:0]  pc,
  input  logic [DW-1:0]  rs1_data,
  input  logic [DW-1:0]  rs2_data,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  a,
  output logic [DW-1:0]  b,
  output logic [4:0]     rd,
  output logic           rd_we,
  output logic           is_branch,
  output logic           illegal
);

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [DW-1:0] imm_i, imm_s, imm_u, shamt, link;
  logic          wants_rd;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Signed size casts sign-extend from instruction bit 31.
  assign imm_i = DW'($signed(inst[31:20]));
  assign imm_s = DW'($signed({inst[31:25], inst[11:7]}));
  assign imm_u = DW'($signed({inst[31:12], 12'b0}));
  assign shamt = DW'(inst[24:20]);
  assign link  = DW'(LINK_OFFSET);

  always_comb begin
    alu_op    = OPW'(ALU_ADD);
    a         = '0;
    b         = '0;
    rd        = inst[11:7];
    rd_we     = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    wants_rd  = 1'b0;

    case (opcode)
      OPC_OP: begin
        a        = rs1_data;
        b        = rs2_data;
        wants_rd = 1'b1;
        if (funct7 == F7_BASE)
          alu_op = OPW'(base_op(funct3));
        else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
          alu_op = OPW'(ALU_SUB);
        else if (funct7 == F7_ALT && funct3 == F3_SR)
          alu_op = OPW'(ALU_SRA);
        else
          illegal = 1'b1;
      end
      OPC_OPIMM: begin
        a        = rs1_data;
        b        = imm_i;
        wants_rd = 1'b1;
        alu_op   = OPW'(base_op(funct3));
        // Shift-immediates reuse imm[11:5] as funct7, so it must be checked.
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          b = shamt;
          if (funct3 == F3_SR && funct7 == F7_ALT)
            alu_op = OPW'(ALU_SRA);
          else if (funct7 != F7_BASE)
            illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        alu_op   = OPW'(ALU_COPY_B);
        b        = imm_u;
        wants_rd = 1'b1;
      end
      OPC_AUIPC: begin
        a        = pc;
        b        = imm_u;
        wants_rd = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU only produces the link value; the target is computed elsewhere.
        a        = pc;
        b        = link;
        wants_rd = 1'b1;
      end
      OPC_BRANCH: begin
        a         = rs1_data;
        b         = rs2_data;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  alu_op = OPW'(ALU_EQ);
          F3_BNE:  alu_op = OPW'(ALU_NE);
          F3_BLT:  alu_op = OPW'(ALU_LT);
          F3_BGE:  alu_op = OPW'(ALU_GE);
          F3_BLTU: alu_op = OPW'(ALU_LTU);
          F3_BGEU: alu_op = OPW'(ALU_GEU);
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        a        = rs1_data;
        b        = imm_i;
        wants_rd = 1'b1;
      end
      OPC_STORE: begin
        a = rs1_data;
        b = imm_s;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      alu_op    = OPW'(ALU_ADD);
      a         = '0;
      b         = '0;
      is_branch = 1'b0;
    end else begin
      rd_we = wants_rd && (rd != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the ALU with a 2-entry skid buffer.
// - clk, rst_n (async, active-low), flush (sync squash of all held beats)
// - in_valid/in_ready + in_inst/in_pc/in_rs1_data/in_rs2_data : upstream beat
// - out_valid/out_ready + out_* : registered ALU request toward execute
// The head entry drives out_*; the skid entry catches one beat while the head
// is stalled, so in_ready depends only on a register.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_inst,
  input  logic [DW-1:0]  in_pc,
  input  logic [DW-1:0]  in_rs1_data,
  input  logic [DW-1:0]  in_rs2_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_alu_op,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [DW-1:0]  out_store_data,
  output logic [4:0]     out_rd,
  output logic           out_rd_we,
  output logic           out_is_branch,
  output logic           out_illegal
);

  // Packed entry: {alu_op, a, b, store_data, rd, rd_we, is_branch, illegal}
  localparam int EW = OPW + 3 * DW + 5 + 3;

  logic [OPW-1:0] dec_alu_op;
  logic [DW-1:0]  dec_a, dec_b;
  logic [4:0]     dec_rd;
  logic           dec_rd_we, dec_is_branch, dec_illegal;
  logic [EW-1:0]  in_word;

  logic [EW-1:0]  head_reg, skid_reg;
  logic           head_valid_reg, skid_valid_reg;
  logic           accept, retire;

  alu_op_decode #(.DW(DW), .OPW(OPW)) u_decode (
    .inst      (in_inst),
    .pc        (in_pc),
    .rs1_data  (in_rs1_data),
    .rs2_data  (in_rs2_data),
    .alu_op    (dec_alu_op),
    .a         (dec_a),
    .b         (dec_b),
    .rd        (dec_rd),
    .rd_we     (dec_rd_we),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  assign in_word = {dec_alu_op, dec_a, dec_b, in_rs2_data, dec_rd,
                    dec_rd_we, dec_is_branch, dec_illegal};

  assign accept = in_valid && !skid_valid_reg;
  assign retire = head_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      head_reg       <= '0;
      skid_reg       <= '0;
    end else if (flush) begin
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!head_valid_reg || retire) begin
      // Head is free this cycle: the older skid beat moves up first. When the
      // skid is occupied, accept is 0, so the skid simply empties.
      if (skid_valid_reg) begin
        head_reg       <= skid_reg;
        head_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else begin
        head_valid_reg <= accept;
        if (accept)
          head_reg <= in_word;
      end
    end else if (accept) begin
      skid_reg       <= in_word;
      skid_valid_reg <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_valid = head_valid_reg;
  assign {out_alu_op, out_a, out_b, out_store_data, out_rd,
          out_rd_we, out_is_branch, out_illegal} = head_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int DW  = 32;
  localparam int OPW = 5;

  localparam logic [4:0] E_ADD = 5'd0,  E_SUB = 5'd1,  E_SLL = 5'd2,  E_SLT = 5'd3;
  localparam logic [4:0] E_SLTU = 5'd4, E_XOR = 5'd5,  E_SRL = 5'd6,  E_SRA = 5'd7;
  localparam logic [4:0] E_OR = 5'd8,   E_AND = 5'd9,  E_COPYB = 5'd10, E_EQ = 5'd11;
  localparam logic [4:0] E_NE = 5'd12,  E_LT = 5'd13,  E_GE = 5'd14, E_LTU = 5'd15;
  localparam logic [4:0] E_GEU = 5'd16;

  logic           clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]    in_inst;
  logic [DW-1:0]  in_pc, in_rs1_data, in_rs2_data;
  logic [OPW-1:0] out_alu_op;
  logic [DW-1:0]  out_a, out_b, out_store_data;
  logic [4:0]     out_rd;
  logic           out_rd_we, out_is_branch, out_illegal;

  alu_issue_stage #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic        we, br, ill;
  } exp_t;

  exp_t       q[$];        // beats the stage must currently hold, oldest first
  logic [4:0] seen_rd[$];  // rd of beats observed leaving the DUT
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the RV32I field rules.
  function automatic exp_t model(input logic [31:0] inst, pc, r1, r2);
    exp_t e;
    logic [4:0]  alu_tab[8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_u;
    alu_tab = '{E_ADD, E_SLL, E_SLT, E_SLTU, E_XOR, E_SRL, E_OR, E_AND};
    f3 = inst[14:12];
    f7 = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_u = {inst[31:12], 12'b0};
    e = '{op: E_ADD, a: 32'd0, b: 32'd0, sd: r2, rd: inst[11:7], we: 1'b0, br: 1'b0, ill: 1'b0};
    case (inst[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.we = 1'b1;
        if (f7 == 7'h00) e.op = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = E_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = E_SRA;
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.a = r1; e.b = imm_i; e.we = 1'b1; e.op = alu_tab[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'd0, inst[24:20]};
          if (f3 == 3'd5 && f7 == 7'h20) e.op = E_SRA;
          else if (f7 != 7'h00) e.ill = 1'b1;
        end
      end
      7'h37: begin e.op = E_COPYB; e.b = imm_u; e.we = 1'b1; end
      7'h17: begin e.a = pc; e.b = imm_u; e.we = 1'b1; end
      7'h6F, 7'h67: begin e.a = pc; e.b = 32'd4; e.we = 1'b1; end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1;
        case (f3)
          3'd0: e.op = E_EQ;
          3'd1: e.op = E_NE;
          3'd4: e.op = E_LT;
          3'd5: e.op = E_GE;
          3'd6: e.op = E_LTU;
          3'd7: e.op = E_GEU;
          default: e.ill = 1'b1;
        endcase
      end
      7'h03: begin e.a = r1; e.b = imm_i; e.we = 1'b1; end
      7'h23: begin e.a = r1; e.b = imm_s; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.op = E_ADD; e.we = 1'b0; e.br = 1'b0; end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs[10];
    logic [31:0] inst;
    int          sel;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h00};
    inst = $urandom;
    sel  = $urandom_range(0, 9);
    inst[6:0] = (sel == 9) ? 7'($urandom) : opcs[sel];
    if (inst[6:0] == 7'h33 || (inst[6:0] == 7'h13 && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5))) begin
      case ($urandom_range(0, 3))
        0, 1: inst[31:25] = 7'h00;
        2:    inst[31:25] = 7'h20;
        default: ;
      endcase
      if (inst[6:0] == 7'h13 && inst[14:12] == 3'd1 && inst[31:25] == 7'h20)
        inst[31:25] = 7'h21;
    end
    return inst;
  endfunction

  // Compare DUT against the model's held beats.
  task automatic compare();
    exp_t e;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0 && out_valid) begin
      e = q[0];
      chk("alu_op", 32'(out_alu_op), 32'(e.op));
      chk("rd", 32'(out_rd), 32'(e.rd));
      chk("rd_we", 32'(out_rd_we), 32'(e.we));
      chk("is_branch", 32'(out_is_branch), 32'(e.br));
      chk("illegal", 32'(out_illegal), 32'(e.ill));
      chk("store_data", out_store_data, e.sd);
      if (!e.ill) begin
        chk("a", out_a, e.a);
        chk("b", out_b, e.b);
      end
    end
  endtask

  // Called at a negedge: check, drive one cycle of inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] inst, pc, r1, r2,
                      input logic ordy, input logic fl);
    logic acc, ret;
    compare();
    in_valid = v; in_inst = inst; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy; flush = fl;
    if (rst_n) begin
      acc = v && (q.size() < 2);
      ret = (q.size() > 0) && ordy;
      if (out_valid && out_ready) seen_rd.push_back(out_rd);
      if (fl) q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(model(inst, pc, r1, r2));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic accepted;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_a", out_a, 32'd0);
    chk("reset_out_rd", 32'(out_rd), 32'd0);
    rst_n = 1'b1;

    // Hand-computed directed beats
    step(1'b1, 32'h00500093, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_op", 32'(out_alu_op), 32'(E_ADD));
    chk("addi_a", out_a, 32'd0);
    chk("addi_b", out_b, 32'd5);
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_we", 32'(out_rd_we), 32'd1);
    step(1'b1, 32'h402081B3, 32'h104, 32'd9, 32'd4, 1'b1, 1'b0);
    chk("sub_op", 32'(out_alu_op), 32'(E_SUB));
    chk("sub_a", out_a, 32'd9);
    chk("sub_b", out_b, 32'd4);
    step(1'b1, 32'h4010D093, 32'h108, 32'h80, 32'd0, 1'b1, 1'b0);
    chk("srai_op", 32'(out_alu_op), 32'(E_SRA));
    chk("srai_b", out_b, 32'd1);
    step(1'b1, 32'h123450B7, 32'h10C, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("lui_op", 32'(out_alu_op), 32'(E_COPYB));
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_rd", 32'(out_rd), 32'd1);
    step(1'b1, 32'h0000007F, 32'h110, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bad_illegal", 32'(out_illegal), 32'd1);
    chk("bad_we", 32'(out_rd_we), 32'd0);
    step(1'b1, 32'h00208463, 32'h114, 32'd3, 32'd3, 1'b1, 1'b0);
    chk("beq_op", 32'(out_alu_op), 32'(E_EQ));
    chk("beq_br", 32'(out_is_branch), 32'd1);
    chk("beq_we", 32'(out_rd_we), 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Backpressure: three beats offered with out_ready low
    seen_rd.delete();
    step(1'b1, 32'h00100293, 32'h200, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00100313, 32'h204, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 32'h00100393, 32'h208, 32'd0, 32'd0, 1'b0, 1'b0);
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      if (q.size() < 2) accepted = 1'b1;
      step(1'b1, 32'h00100393, 32'h208, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    chk("bp_third_accepted", 32'(accepted), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_count", 32'(seen_rd.size()), 32'd3);
    if (seen_rd.size() == 3) begin
      chk("bp_order0", 32'(seen_rd[0]), 32'd5);
      chk("bp_order1", 32'(seen_rd[1]), 32'd6);
      chk("bp_order2", 32'(seen_rd[2]), 32'd7);
    end

    // Flush with both entries full and a beat offered
    step(1'b1, 32'h00100293, 32'h300, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00100313, 32'h304, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00100493, 32'h308, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic with backpressure and occasional flush
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) < 70, rand_inst(), $urandom, $urandom, $urandom,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
    end

    // Asynchronous reset in the middle of traffic
    step(1'b1, 32'h00100293, 32'h400, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00100313, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_b", out_b, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h00500093, 32'h500, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_op", 32'(out_alu_op), 32'(E_ADD));
    chk("post_rst_b", out_b, 32'd5);
    chk("post_rst_rd", 32'(out_rd), 32'd1);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
